// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round counts, index type, controller
// state encoding and the round-constant table.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [3:0] round_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } ks_state_t;

    // Entry 0 is never used; rounds are numbered from 1.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte, shared by SubWord in the key
// schedule and SubBytes in the cipher datapath.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);

    // Row-major table: entry 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = SBOX[val];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key expansion: one round key per cycle into an (NR+1)-entry
// buffer, then round keys served by index with one-cycle read latency.
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic         rk_err
);

    import aes_pkg::*;

    localparam round_idx_t LAST_IDX = round_idx_t'(NR);

    ks_state_t    state;
    round_idx_t   r;
    logic [127:0] rk [0:NR];

    logic         accept;
    logic [127:0] prev_key;
    logic [127:0] next_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  temp_word;
    logic [31:0]  w0n, w1n, w2n, w3n;

    assign accept = key_valid && key_ready;

    // One FIPS-197 expansion round from the previous buffer entry.
    assign prev_key  = rk[r - 4'd1];
    assign rot_word  = {prev_key[23:0], prev_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .val (rot_word[8*i +: 8]),
            .sub (sub_word[8*i +: 8])
        );
    end

    assign temp_word = sub_word ^ {RCON[r], 24'h000000};
    assign w0n       = prev_key[127:96] ^ temp_word;
    assign w1n       = prev_key[95:64]  ^ w0n;
    assign w2n       = prev_key[63:32]  ^ w1n;
    assign w3n       = prev_key[31:0]   ^ w2n;
    assign next_key  = {w0n, w1n, w2n, w3n};

    // Control FSM; handshake and status flags are registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            r          <= '0;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_READY: begin
                    if (accept) begin
                        state      <= ST_EXPAND;
                        r          <= 4'd1;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    if (r == LAST_IDX) begin
                        state      <= ST_READY;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    r          <= '0;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    keys_ready <= 1'b0;
                end
            endcase
        end
    end

    // Buffer is deliberately left unreset; a reload always precedes use.
    always_ff @(posedge clk) begin
        if (accept) begin
            rk[0] <= key_in;
        end else if (state == ST_EXPAND) begin
            rk[r] <= next_key;
        end
    end

    // Read port samples the pre-edge buffer, so a same-edge reload is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk_data  <= '0;
        end else begin
            rk_valid <= rk_req;
            if (rk_req) begin
                if (state == ST_READY && rk_idx <= LAST_IDX) begin
                    rk_data <= rk[rk_idx];
                    rk_err  <= 1'b0;
                end else begin
                    rk_data <= '0;
                    rk_err  <= 1'b1;
                end
            end else begin
                rk_err <= 1'b0;
            end
        end
    end

endmodule
